// File: rtl/nla_pkg.sv
// Shared definitions for the NonLinearApprox datapath: word format defaults,
// the MAC end-of-stream sentinel and the feeder sequencer state encoding.
package nla_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_LINES_DEF = 5;
  localparam logic [31:0] NAN_WORD = 32'h7F90_0000;

  typedef enum logic [2:0] {
    IDLE,
    SEND_SIG,
    SIG_NAN,
    SEND_COEF,
    COEF_NAN,
    DONE
  } feeder_state_t;

endpackage

// File: rtl/feeder_buf.sv
// One-write/one-read register array. The read port is combinational so the
// sequencer can register the next word in the same cycle it picks the address.
module feeder_buf
  import nla_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_LINES = ADDR_LINES_DEF
) (
  input  logic                  clk_i,
  input  logic                  wr_en_i,
  input  logic [ADDR_LINES-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic [ADDR_LINES-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_LINES];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/mac_stream_feeder.sv
// Streams a buffered sample batch, then a coefficient set, into the MAC,
// each followed by the NaN end-of-stream sentinel, honouring per-port full.
module mac_stream_feeder #(
  parameter int DATA_WIDTH = nla_pkg::DATA_WIDTH_DEF,
  parameter int ADDR_LINES = nla_pkg::ADDR_LINES_DEF,
  parameter logic [DATA_WIDTH-1:0] NAN_WORD = nla_pkg::NAN_WORD
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  sig_wr_en_i,
  input  logic                  coeff_wr_en_i,
  input  logic [ADDR_LINES-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  start_i,
  input  logic [ADDR_LINES:0]   sig_count_i,
  input  logic [ADDR_LINES:0]   coeff_count_i,
  input  logic                  full_mul_i,
  input  logic                  full_adder_i,
  output logic [DATA_WIDTH-1:0] signal_fifo_o,
  output logic                  signal_valid_o,
  output logic [DATA_WIDTH-1:0] coeff_fifo_o,
  output logic                  coeff_valid_o,
  output logic                  busy_o,
  output logic                  done_o
);
  import nla_pkg::*;

  localparam logic [ADDR_LINES:0] MAX_CNT = {1'b1, {ADDR_LINES{1'b0}}};

  function automatic logic [ADDR_LINES:0] sat_count(input logic [ADDR_LINES:0] c);
    return (c > MAX_CNT) ? MAX_CNT : c;
  endfunction

  feeder_state_t         state_q, state_d;
  logic [ADDR_LINES:0]   idx_q, idx_d, idx_inc;
  logic [ADDR_LINES:0]   sig_cnt_q, sig_cnt_d, coef_cnt_q, coef_cnt_d;
  logic [DATA_WIDTH-1:0] sig_data_q, sig_data_d, coef_data_q, coef_data_d;
  logic                  sig_vld_q, sig_vld_d, coef_vld_q, coef_vld_d;
  logic                  busy_q, busy_d, done_q, done_d;
  logic                  sig_we, coef_we, sig_xfer, coef_xfer;
  logic [ADDR_LINES-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] sig_rd, coef_rd, sig_word, coef_word;

  assign sig_we    = sig_wr_en_i & ~busy_q;
  assign coef_we   = coeff_wr_en_i & ~busy_q;
  assign sig_xfer  = sig_vld_q & ~full_mul_i;
  assign coef_xfer = coef_vld_q & ~full_adder_i;
  assign idx_inc   = idx_q + 1'b1;
  assign rd_addr   = idx_d[ADDR_LINES-1:0];

  feeder_buf #(.DATA_WIDTH(DATA_WIDTH), .ADDR_LINES(ADDR_LINES)) u_sig_buf (
    .clk_i(clk_i), .wr_en_i(sig_we), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
    .rd_addr_i(rd_addr), .rd_data_o(sig_rd)
  );

  feeder_buf #(.DATA_WIDTH(DATA_WIDTH), .ADDR_LINES(ADDR_LINES)) u_coef_buf (
    .clk_i(clk_i), .wr_en_i(coef_we), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
    .rd_addr_i(rd_addr), .rd_data_o(coef_rd)
  );

  // A write landing with start must reach the very first word read out
  assign sig_word  = (sig_we && wr_addr_i == rd_addr) ? wr_data_i : sig_rd;
  assign coef_word = (coef_we && wr_addr_i == rd_addr) ? wr_data_i : coef_rd;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      sig_cnt_q   <= '0;
      coef_cnt_q  <= '0;
      sig_data_q  <= '0;
      coef_data_q <= '0;
      sig_vld_q   <= 1'b0;
      coef_vld_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      sig_cnt_q   <= sig_cnt_d;
      coef_cnt_q  <= coef_cnt_d;
      sig_data_q  <= sig_data_d;
      coef_data_q <= coef_data_d;
      sig_vld_q   <= sig_vld_d;
      coef_vld_q  <= coef_vld_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    sig_cnt_d  = sig_cnt_q;
    coef_cnt_d = coef_cnt_q;
    unique case (state_q)
      IDLE: if (start_i) begin
        sig_cnt_d  = sat_count(sig_count_i);
        coef_cnt_d = sat_count(coeff_count_i);
        idx_d      = '0;
        state_d    = (sig_cnt_d == '0) ? SIG_NAN : SEND_SIG;
      end
      SEND_SIG: if (sig_xfer) begin
        if (idx_inc == sig_cnt_q) state_d = SIG_NAN;
        else                      idx_d   = idx_inc;
      end
      SIG_NAN: if (sig_xfer) begin
        idx_d   = '0;
        state_d = (coef_cnt_q == '0) ? COEF_NAN : SEND_COEF;
      end
      SEND_COEF: if (coef_xfer) begin
        if (idx_inc == coef_cnt_q) state_d = COEF_NAN;
        else                       idx_d   = idx_inc;
      end
      COEF_NAN: if (coef_xfer) state_d = DONE;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Outputs are registered from the upcoming state so a word appears the
  // cycle after its predecessor transfers
  always_comb begin
    sig_data_d  = sig_data_q;
    coef_data_d = coef_data_q;
    sig_vld_d   = 1'b0;
    coef_vld_d  = 1'b0;
    busy_d      = 1'b1;
    done_d      = 1'b0;
    unique case (state_d)
      SEND_SIG:  begin sig_vld_d  = 1'b1; sig_data_d  = sig_word;  end
      SIG_NAN:   begin sig_vld_d  = 1'b1; sig_data_d  = NAN_WORD;  end
      SEND_COEF: begin coef_vld_d = 1'b1; coef_data_d = coef_word; end
      COEF_NAN:  begin coef_vld_d = 1'b1; coef_data_d = NAN_WORD;  end
      DONE:      begin busy_d = 1'b0; done_d = 1'b1; end
      default:   busy_d = 1'b0;
    endcase
  end

  assign signal_fifo_o  = sig_data_q;
  assign signal_valid_o = sig_vld_q;
  assign coeff_fifo_o   = coef_data_q;
  assign coeff_valid_o  = coef_vld_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;

endmodule
